// File: rtl/pulse_len_pkg.sv
// Shared types, length constants and the length-to-value rule for the pulse-length decoder.
package pulse_len_pkg;

  typedef enum logic [2:0] {
    ARM      = 3'd0,
    IDLE     = 3'd1,
    MEASURE  = 3'd2,
    WAIT_RDY = 3'd3,
    SEND     = 3'd4,
    WAIT_ACK = 3'd5
  } state_e;

  localparam int unsigned NUM_W_DEF = 2;
  localparam int unsigned MIN_LEN   = 2;

  function automatic int unsigned max_len(input int unsigned num_w);
    return 32'd1 << (num_w + 1);
  endfunction

  localparam int unsigned MAX_LEN = max_len(NUM_W_DEF);
  localparam int unsigned SAT_LEN = MAX_LEN + 1;

  // Even lengths give len/2-1; odd lengths round up to the next even length.
  function automatic int unsigned len_to_num(input int unsigned len);
    return ((len + 1) / 2) - 1;
  endfunction

endpackage

// File: rtl/pulse_len_decoder_meter.sv
// Saturating high-time counter with length classification for the pulse-length decoder.
module pulse_meter
  import pulse_len_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF,
  parameter int CNT_W = NUM_W + 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             in_i,
  input  logic             start_i,
  input  logic             run_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             even_ok_o,
  output logic             odd_ok_o,
  output logic             overlong_o
);

  localparam int unsigned    MAX_L = max_len(NUM_W);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_L);
  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(MAX_L + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturation parks the count one past the longest legal pulse, so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i && in_i) begin
      cnt_d = CNT_W'(1);
    end else if (run_i && in_i && (cnt_q != SAT_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign overlong_o = (cnt_q == SAT_C);
  assign even_ok_o  = !cnt_q[0] && (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
  assign odd_ok_o   = cnt_q[0] && (cnt_q < MAX_C);

endmodule

// File: rtl/pulse_len_decoder.sv
// Pulse-length decoder: measures high pulses and offers numero on the dav_/rfd link.
// Build option: define ODD_ROUND_EN to round odd lengths up instead of rejecting them.
module pulse_len_decoder
  import pulse_len_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF,
  parameter int CNT_W = NUM_W + 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  input  logic             rfd,
  output logic             dav_,
  output logic [NUM_W-1:0] numero,
  output logic             err
);

  // Handshake: we raise data-available (dav_=0) only after seeing rfd=1, hold
  // numero until the consumer drops rfd, then release dav_ and wait for rfd to
  // rise again before arming for the next pulse.
  state_e           state_q, state_d;
  logic             dav_q, dav_d;
  logic [NUM_W-1:0] numero_q, numero_d;
  logic             err_q, err_d;

  logic             start, run;
  logic [CNT_W-1:0] cnt;
  logic             even_ok, odd_ok, overlong;
  logic             accept;

  pulse_meter #(
    .NUM_W(NUM_W),
    .CNT_W(CNT_W)
  ) u_meter (
    .clock_i   (clock),
    .reset_i   (reset),
    .in_i      (in),
    .start_i   (start),
    .run_i     (run),
    .cnt_o     (cnt),
    .even_ok_o (even_ok),
    .odd_ok_o  (odd_ok),
    .overlong_o(overlong)
  );

`ifdef ODD_ROUND_EN
  assign accept = (even_ok || odd_ok) && !overlong;
`else
  assign accept = even_ok;
  logic unused_odd;
  assign unused_odd = odd_ok ^ overlong;
`endif

  always_comb begin
    state_d  = state_q;
    dav_d    = dav_q;
    numero_d = numero_q;
    err_d    = 1'b0;
    start    = 1'b0;
    run      = 1'b0;
    case (state_q)
      ARM:      if (!in) state_d = IDLE;
      IDLE: begin
        if (in) begin
          start   = 1'b1;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (in) begin
          run = 1'b1;
        end else if (accept) begin
          numero_d = NUM_W'(len_to_num(32'(cnt)));
          state_d  = WAIT_RDY;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_RDY: begin
        if (rfd) begin
          dav_d   = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!rfd) begin
          dav_d   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: if (rfd) state_d = ARM;
      default:  state_d = ARM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ARM;
      dav_q    <= 1'b1;
      numero_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dav_q    <= dav_d;
      numero_q <= numero_d;
      err_q    <= err_d;
    end
  end

  assign dav_   = dav_q;
  assign numero = numero_q;
  assign err    = err_q;

endmodule

// File: doc/pulse_len_decoder.md
Name: pulse_len_decoder

Overview:
Receive-side counterpart of the numero→pulse generator. Samples a serial pulse line, measures each high pulse in clock cycles and decodes length 2*(numero+1) back to a NUM_W-bit numero. Delivers the value to a downstream consumer as producer on the team's dav_/rfd handshake. Sits at the far end of the pulse link, ahead of any consumer of numero.

Parameters:
NUM_W, 2, width of numero; accepted pulse lengths are 2,4,...,2^(NUM_W+1) cycles
CNT_W, NUM_W+2, width of the internal length counter (must hold 2^(NUM_W+1)+1)

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
in  input  1  pulse line, synchronous to clock
rfd  input  1  consumer ready-for-data, active-high
dav_  output  1  data-available, active-low
numero  output  NUM_W  decoded value, valid while dav_=0
err  output  1  one-cycle pulse on a rejected measurement

Behaviour:
- All outputs registered. Reset (reset=1 at a posedge): dav_=1, numero=0, err=0, counter=0, state=ARM.
- ARM: wait for in sampled 0 (no pulse already in progress at reset counts) -> IDLE.
- IDLE: in sampled 1 -> MEASURE, cnt=1.
- MEASURE: each posedge with in=1: cnt=cnt+1, saturating at 2^(NUM_W+1)+1 (marks overlong). First posedge with in=0: evaluate cnt:
  - valid (cnt even, 2<=cnt<=2^(NUM_W+1)): numero<=cnt/2-1 at that edge -> WAIT_RDY.
  - invalid (odd, or saturated): err=1 for exactly one cycle, numero unchanged -> IDLE.
- WAIT_RDY: dav_=1; rfd sampled 1 -> SEND, dav_<=0 at that edge.
- SEND: dav_=0, numero stable; rfd sampled 0 -> dav_<=1 -> WAIT_ACK.
- WAIT_ACK: dav_=1; rfd sampled 1 -> ARM (next pulse measured only from a fresh 0->1).
- Latency: fall of in sampled at edge k -> dav_ low at edge k+1 if rfd=1 already at edge k+1.
- Pulses starting while in WAIT_RDY/SEND/WAIT_ACK: ignored entirely, no err; ARM discards any pulse still high on return.
- in stuck high: counter saturates, no wrap; on eventual fall err=1.
- numero holds its last value outside SEND; never changes while dav_=0.
- reset mid-MEASURE or mid-SEND: dav_ returns to 1 at that edge, partial measurement discarded, no err.
- Single-cycle glitch high (cnt=1): odd -> err.

Optional Feature:
Macro ODD_ROUND_EN. Defined: odd cnt in range 1..2^(NUM_W+1)-1 rounded up (numero=(cnt+1)/2-1) and delivered normally; err only for saturated/overlong. Undefined: any odd length rejected with err as above.

Decomposition:
- Package pulse_len_pkg: state enum (ARM, IDLE, MEASURE, WAIT_RDY, SEND, WAIT_ACK), constants MIN_LEN=2, MAX_LEN=2^(NUM_W+1), SAT_LEN=MAX_LEN+1, function len_to_num.
- Sub-module pulse_meter: edge detect + saturating counter + valid/overlong/odd flags; top holds FSM and handshake.

Test Plan:
- Reset 2 cycles, in=0, rfd=1 -> dav_=1, numero=0, err=0 at first negedge after reset release.
- in high 4 cycles, rfd=1 -> dav_ low one edge after fall, numero=01; consumer drops rfd -> dav_ back to 1; rfd up -> ready for next.
- Sequence 2,6,8 cycles with consumer handshake -> numero 00,10,11 in order, each held stable while dav_=0.
- in high 3 cycles -> err pulse 1 cycle, dav_ stays 1 (macro off); with ODD_ROUND_EN numero=01 delivered, err=0.
- in high 12 cycles (NUM_W=2) -> err=1 once, no dav_; counter not wrapped (no false numero).
- rfd held 0 after a 6-cycle pulse; second pulse during wait; reset asserted mid-SEND -> only first value offered, second ignored, dav_=1 immediately after reset edge.
